uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single peripheral UART transmitter between NREQ byte requesters, e.g. CPU store path (req 0) and debug monitor (req 1).
- Selects one requester round-robin, latches its byte, drives the UART tx handshake (tx_data/tx_data_valid), then waits for tx_data_ack before serving the next byte.
- Supports locked bursts (a requester keeps the transmitter for consecutive bytes) with a starvation cap.
- Sits between the requesters and the uart instance inside peripherals.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_BURST, 16, maximum consecutive locked bytes per grant before lock is overridden once.
- TIMEOUT_CYCLES, 65535, ack wait limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  single block clock; the uart shares this domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  byte of requester i at [8i+7:8i].
- req_lock  in  NREQ  requester i asks to keep the grant after the current byte.
- req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i]&req_ready[i].
- tx_data  out  8  byte to uart, held stable from ISSUE until ack.
- tx_data_valid  out  1  one-cycle start pulse to uart.
- tx_data_ack  in  1  one-cycle pulse from uart: byte transmitted.
- busy  out  1  state != IDLE.
- grant_id  out  $clog2(NREQ)  requester owning the current byte.
- err_timeout  out  1  one-cycle pulse on ack timeout (0 when feature absent).

Behaviour:
- Reset values: state=IDLE; req_ready=0; tx_data=0; tx_data_valid=0; busy=0; grant_id=0; err_timeout=0; last_grant=NREQ-1; lock_active=0; burst_cnt=0.
- IDLE:
  - Candidate = first i with req_valid[i], searching from last_grant+1 with wrap modulo NREQ.
  - If lock_active, the candidate is last_grant only; other requesters are not served.
  - req_ready[candidate] is combinational in IDLE. On that handshake cycle: latch tx_data=req_data[candidate], grant_id=candidate, last_grant=candidate; go to ISSUE.
  - If no candidate, stay in IDLE; req_ready=0.
- ISSUE: tx_data_valid=1 for exactly this cycle; go to WAIT_ACK. An ack seen in this cycle is taken as WAIT_ACK completion.
- WAIT_ACK: hold tx_data. On tx_data_ack, go to IDLE and update the lock:
  - If req_lock[grant_id] is set and burst_cnt < MAX_BURST-1: lock_active=1, burst_cnt+=1.
  - Otherwise: lock_active=0, burst_cnt=0. The next IDLE search then starts at grant_id+1, so others get a turn even if the lock is still asserted.
- Latency: handshake cycle N, tx_data_valid at N+1. Earliest next handshake is the cycle after the ack.
- Simultaneous requests: only one ready per cycle. Rotation guarantees every valid requester is served within NREQ bytes when unlocked, or within MAX_BURST+NREQ-1 bytes when another requester is locked.
- req_valid dropped before handshake: no transfer, no state change.
- tx_data_ack outside ISSUE/WAIT_ACK: ignored.
- Reset mid-operation (any state): immediately back to IDLE with reset values; the byte is lost, and tx_data_valid does not reassert for it.
- busy = (state != IDLE).

Optional Feature:
- Macro UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entering ISSUE and increments each WAIT_ACK cycle.
  - On reaching TIMEOUT_CYCLES without an ack: pulse err_timeout, clear lock_active and burst_cnt, go to IDLE.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no err_timeout.
- Undefined: no counter; err_timeout tied 0; WAIT_ACK waits indefinitely.

Decomposition:
- Shared package peri_pkg holds the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2) and SOC2_PERI_UART_DR-style address constants used by peripherals.
- One sub-module, rr_pick: combinational round-robin priority search with inputs req vector, last index and mask, and outputs one-hot grant plus index.
- The FSM, lock logic and timeout stay in uart_tx_arbiter.

Test Plan:
- Single byte: req_valid=01, req_data[7:0]=8'h41 → req_ready=01 for 1 cycle; next cycle tx_data=8'h41 with tx_data_valid pulse; ack after 10 cycles → busy falls the cycle after the ack.
- Contention: both valid continuously with bytes 8'hA0 and 8'hB0, no lock, after reset → grant order 0,1,0,1; tx_data sequence A0,B0,A0,B0.
- Lock cap: MAX_BURST=4, req0 lock=1 and valid with req1 valid → four req0 bytes, then one req1 byte, then req0 again.
- Ignored ack and mid-op reset: ack during IDLE → no effect; rst asserted in WAIT_ACK → busy=0 and tx_data=0 immediately; no tx_data_valid until a new request.
- Timeout (with UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): no ack → err_timeout pulses once 20 WAIT_ACK cycles after ISSUE, state returns to IDLE; repeat with ack on cycle 20 → no err_timeout.

Source files
------------

// File: rtl/peri_pkg.sv
// Shared peripheral package.
//
// Holds the arbiter state encoding used by uart_tx_arbiter and the
// peripheral address map constants referenced across the peripherals
// block (bus decoders, firmware-facing headers, benches).
//
// No ports: package only.

package peri_pkg;

  // Arbiter FSM encoding; values are fixed so debug taps and traces stay
  // stable across revisions.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } arb_state_e;

  // Peripheral address map.
  localparam logic [31:0] SOC2_PERI_BASE    = 32'h4000_0000;
  localparam logic [31:0] SOC2_PERI_UART_DR = SOC2_PERI_BASE + 32'h0000_1000;
  localparam logic [31:0] SOC2_PERI_UART_SR = SOC2_PERI_BASE + 32'h0000_1004;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority search.
//
// Finds the first requester whose bit is set in (req & mask), starting at
// index last+1 and wrapping modulo N. The requester at 'last' is therefore
// the lowest priority and is only picked when nobody else is eligible.
//
// Ports:
//   req   in  N   request vector
//   last  in  IW  index of the most recent winner
//   mask  in  N   eligibility mask (1 = may be picked)
//   grant out N   one-hot winner (all zero when nothing eligible)
//   idx   out IW  binary index of the winner (0 when nothing eligible)
//   found out 1   a winner exists

module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] elig;

  assign elig = req & mask;

  // Walk the ring from last+1; the first eligible hit wins.
  always_comb begin : search
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last) + k) % N;
      if (!found && elig[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte
// requesters, with locked bursts capped at MAX_BURST bytes per grant.
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to add an ack timeout of
// TIMEOUT_CYCLES WAIT_ACK cycles. Without it, err_timeout is tied low and
// the arbiter waits for the ack indefinitely.
//
// Ports:
//   clk           in  1          block clock (shared with the uart)
//   rst           in  1          asynchronous active-high reset
//   req_valid     in  NREQ       per-requester byte valid
//   req_data      in  8*NREQ     byte of requester i at [8i+7:8i]
//   req_lock      in  NREQ       requester i wants to keep the grant
//   req_ready     out NREQ       one-hot accept (combinational in IDLE)
//   tx_data       out 8          byte to uart, held from ISSUE until ack
//   tx_data_valid out 1          one-cycle start pulse to uart
//   tx_data_ack   in  1          one-cycle "byte sent" pulse from uart
//   busy          out 1          state != IDLE
//   grant_id      out clog2(NREQ) owner of the current byte
//   err_timeout   out 1          one-cycle pulse on ack timeout

module uart_tx_arbiter
  import peri_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [8*NREQ-1:0]        req_data,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_data_ack,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     err_timeout
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_data_valid_q, tx_data_valid_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               lock_active_q, lock_active_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               complete;

  logic [NREQ-1:0]    pick_mask;
  logic [NREQ-1:0]    pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0]        wait_cnt_q, wait_cnt_d;
  logic               err_timeout_q, err_timeout_d;
`endif

  // While a burst is locked only the previous winner is eligible.
  always_comb begin
    pick_mask = '1;
    if (lock_active_q) begin
      pick_mask               = '0;
      pick_mask[last_grant_q] = 1'b1;
    end
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant_q),
    .mask  (pick_mask),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Ready is offered only in IDLE and never while reset is held, so no
  // requester believes a byte was taken during reset.
  assign req_ready = (state_q == IDLE && !rst) ? pick_grant : '0;

  // Next-state logic. A completion (ack in ISSUE or WAIT_ACK) returns to
  // IDLE and decides whether the current owner keeps the transmitter.
  always_comb begin
    state_d         = state_q;
    tx_data_d       = tx_data_q;
    tx_data_valid_d = 1'b0;
    grant_id_d      = grant_id_q;
    last_grant_d    = last_grant_q;
    lock_active_d   = lock_active_q;
    burst_cnt_d     = burst_cnt_q;
    complete        = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wait_cnt_d      = wait_cnt_q;
    err_timeout_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          tx_data_d       = req_data[pick_idx*8 +: 8];
          grant_id_d      = pick_idx;
          last_grant_d    = pick_idx;
          tx_data_valid_d = 1'b1;
          state_d         = ISSUE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wait_cnt_d      = '0;
`endif
        end
      end

      ISSUE: begin
        if (tx_data_ack) begin
          complete = 1'b1;
        end else begin
          state_d = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (tx_data_ack) begin
          complete = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          // This is the TIMEOUT_CYCLES-th WAIT_ACK cycle without an ack.
          err_timeout_d = 1'b1;
          lock_active_d = 1'b0;
          burst_cnt_d   = '0;
          state_d       = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Burst cap: after MAX_BURST locked bytes the lock is dropped once, and
    // the search restarts after the owner so others get a turn.
    if (complete) begin
      state_d = IDLE;
      if (req_lock[grant_id_q] && (burst_cnt_q < BURST_W'(MAX_BURST - 1))) begin
        lock_active_d = 1'b1;
        burst_cnt_d   = burst_cnt_q + 1'b1;
      end else begin
        lock_active_d = 1'b0;
        burst_cnt_d   = '0;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      tx_data_q       <= '0;
      tx_data_valid_q <= 1'b0;
      grant_id_q      <= '0;
      last_grant_q    <= IDX_W'(NREQ - 1);
      lock_active_q   <= 1'b0;
      burst_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      tx_data_q       <= tx_data_d;
      tx_data_valid_q <= tx_data_valid_d;
      grant_id_q      <= grant_id_d;
      last_grant_q    <= last_grant_d;
      lock_active_q   <= lock_active_d;
      burst_cnt_q     <= burst_cnt_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Ack wait counter and timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  logic timeout_unused;

  // The limit only matters when the timeout logic is built.
  assign timeout_unused = (TIMEOUT_CYCLES == 0);
  assign err_timeout    = 1'b0;
`endif

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_data_valid_q;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=2, MAX_BURST=4,
// TIMEOUT_CYCLES=20). Expected bytes are queued when stimulus is applied
// and a monitor pops and compares them on every tx_data_valid pulse.

module tb_uart_tx_arbiter;
  import peri_pkg::*;

  localparam int NREQ = 2;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [15:0]     req_data;
  logic [NREQ-1:0] req_lock;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      tx_data;
  logic            tx_data_valid;
  logic            tx_data_ack;
  logic            busy;
  logic            grant_id;
  logic            err_timeout;

  logic            auto_ack;
  logic            auto_ack_pulse;
  logic            man_ack;
  int              ack_delay;

  int              checks;
  int              errors;
  int              popped;

  typedef struct packed {
    logic [7:0] gid;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  assign tx_data_ack = auto_ack_pulse | man_ack;

  uart_tx_arbiter #(
    .NREQ           (NREQ),
    .MAX_BURST      (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_lock      (req_lock),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ack   (tx_data_ack),
    .busy          (busy),
    .grant_id      (grant_id),
    .err_timeout   (err_timeout)
  );

  // 10 ns clock, active edge at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [15:0] data,
                               input logic [NREQ-1:0] lock);
    req_valid = valid;
    req_data  = data;
    req_lock  = lock;
  endtask

  task automatic pushExpected(input logic [7:0] gid, input logic [7:0] data);
    exp_t e;
    e.gid  = gid;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitPopped(input int target, input int budget);
    int n;
    n = 0;
    while (popped < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("wait_bytes", 32'(popped >= target), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idle", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every start pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && tx_data_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_tx_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        popped++;
        checkOutput("sb_tx_data", 32'(tx_data), 32'(mon_e.data));
        checkOutput("sb_grant_id", 32'(grant_id), 32'(mon_e.gid));
      end
    end
  end

  // Uart model: acknowledges each issued byte ack_delay cycles later.
  initial begin
    auto_ack_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && tx_data_valid) begin
        repeat (ack_delay) @(posedge clk);
        #1 auto_ack_pulse = 1'b1;
        @(posedge clk);
        #1 auto_ack_pulse = 1'b0;
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    popped    = 0;
    auto_ack  = 1'b0;
    man_ack   = 1'b0;
    ack_delay = 2;
    rst       = 1'b1;
    applyStimulus(2'b11, 16'hB0A0, 2'b00);
    $display("[TB] uart DR 0x%08h SR 0x%08h", SOC2_PERI_UART_DR, SOC2_PERI_UART_SR);

    // Reset values, with requests pending during reset.
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
    applyStimulus(2'b00, 16'h0000, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single byte from requester 0, ack 10 cycles later.
    @(posedge clk);
    #1 applyStimulus(2'b01, 16'h0041, 2'b00);
    pushExpected(8'd0, 8'h41);
    @(negedge clk);
    checkOutput("t1_ready", 32'(req_ready), 32'h1);
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1 applyStimulus(2'b00, 16'h0000, 2'b00);
    @(negedge clk);
    checkOutput("t1_ready_drop", 32'(req_ready), 32'd0);
    checkOutput("t1_busy_issue", 32'(busy), 32'd1);
    checkOutput("t1_tx_valid", 32'(tx_data_valid), 32'd1);
    @(negedge clk);
    checkOutput("t1_tx_valid_once", 32'(tx_data_valid), 32'd0);
    checkOutput("t1_tx_data_hold", 32'(tx_data), 32'h41);
    repeat (8) @(negedge clk);
    man_ack = 1'b1;
    checkOutput("t1_busy_ack_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    man_ack = 1'b0;
    checkOutput("t1_busy_falls", 32'(busy), 32'd0);

    // Ack while idle has no effect.
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    checkOutput("t2_busy", 32'(busy), 32'd0);
    checkOutput("t2_tx_valid", 32'(tx_data_valid), 32'd0);
    checkOutput("t2_tx_data", 32'(tx_data), 32'h41);

    // Contention without lock: strict alternation starting at requester 0.
    doReset();
    auto_ack = 1'b1;
    #1 applyStimulus(2'b11, 16'hB0A0, 2'b00);
    pushExpected(8'd0, 8'hA0);
    pushExpected(8'd1, 8'hB0);
    pushExpected(8'd0, 8'hA0);
    pushExpected(8'd1, 8'hB0);
    waitPopped(popped + 4, 200);
    #1 applyStimulus(2'b00, 16'h0000, 2'b00);
    waitIdle(50);
    checkOutput("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Locked burst from requester 0 capped at four bytes.
    doReset();
    #1 applyStimulus(2'b11, 16'hB0A0, 2'b01);
    for (int i = 0; i < 4; i++) pushExpected(8'd0, 8'hA0);
    pushExpected(8'd1, 8'hB0);
    pushExpected(8'd0, 8'hA0);
    waitPopped(popped + 6, 300);
    #1 applyStimulus(2'b00, 16'h0000, 2'b00);
    waitIdle(50);
    checkOutput("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    auto_ack = 1'b0;

    // Reset while waiting for the ack drops the byte.
    doReset();
    #1 applyStimulus(2'b10, 16'h5A00, 2'b00);
    pushExpected(8'd1, 8'h5A);
    @(negedge clk);
    checkOutput("t5_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_busy_wait", 32'(busy), 32'd1);
    checkOutput("t5_tx_data_wait", 32'(tx_data), 32'h5A);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("t5_rst_grant_id", 32'(grant_id), 32'd0);
    applyStimulus(2'b00, 16'h0000, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("t5_no_reissue", 32'(tx_data_valid), 32'd0);
    checkOutput("t5_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // No ack: timeout after 20 WAIT_ACK cycles.
    doReset();
    #1 applyStimulus(2'b01, 16'h00C3, 2'b00);
    pushExpected(8'd0, 8'hC3);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(2'b00, 16'h0000, 2'b00);
    repeat (20) @(negedge clk);
    checkOutput("t6_no_err_early", 32'(err_timeout), 32'd0);
    @(negedge clk);
    checkOutput("t6_err_pulse", 32'(err_timeout), 32'd1);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t6_err_once", 32'(err_timeout), 32'd0);

    // Ack on the 20th WAIT_ACK cycle wins over the timeout.
    @(posedge clk);
    #1 applyStimulus(2'b01, 16'h00C4, 2'b00);
    pushExpected(8'd0, 8'hC4);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(2'b00, 16'h0000, 2'b00);
    repeat (20) @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    checkOutput("t7_no_err", 32'(err_timeout), 32'd0);
    checkOutput("t7_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t7_no_err_late", 32'(err_timeout), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
